// File: rtl/strait_sched_pkg.sv
// Shared types and bit indices for the STRAIT multi-tile self-test scheduler.
// Optional retry-on-timeout behaviour is enabled with STRAIT_SCHED_RETRY_EN.
package strait_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SELECT,
        S_MB_START,
        S_MB_WAIT,
        S_LB_START,
        S_LB_WAIT_SA,
        S_LB_WAIT_TD,
        S_REC_WAIT,
        S_LOG,
        S_DONE
    } sched_state_e;

    localparam int FC_MBIST   = 0;
    localparam int FC_TD      = 1;
    localparam int FC_UNREC   = 2;
    localparam int FC_TIMEOUT = 3;

    localparam int PM_MBIST = 0;
    localparam int PM_LBIST = 1;
    localparam int PM_REC   = 2;

endpackage

// File: rtl/strait_sched_tile_pick.sv
// Finds the lowest enabled tile index at or above a start index.
// Returns found=0 when no enabled tile remains.
module strait_sched_tile_pick
    import strait_sched_pkg::*;
#(
    parameter int NUM_TILES     = 4,
    parameter int TILE_ID_WIDTH = 2
) (
    input  logic [NUM_TILES-1:0]     i_enable,
    input  logic [TILE_ID_WIDTH-1:0] i_start,
    output logic                     o_found,
    output logic [TILE_ID_WIDTH-1:0] o_index
);

    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        // Descending scan so the lowest qualifying index is written last
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            if (i_enable[i] && (i >= int'(i_start))) begin
                o_found = 1'b1;
                o_index = TILE_ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/strait_test_scheduler.sv
// Walks enabled STRAIT tiles through MBIST, LBIST and BISR recovery phases.
// Define STRAIT_SCHED_RETRY_EN to allow one retry per phase on watchdog timeout.
module strait_test_scheduler
    import strait_sched_pkg::*;
#(
    parameter int NUM_TILES     = 4,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int TILE_ID_WIDTH = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sched_start,
    input  logic [2:0]                 phase_mask,
    input  logic [NUM_TILES-1:0]       tile_enable,
    input  logic [TIMEOUT_WIDTH-1:0]   timeout_limit,
    input  logic [NUM_TILES-1:0]       tile_test_done,
    input  logic [NUM_TILES-1:0]       tile_MBIST_FAIL,
    input  logic [NUM_TILES-1:0]       tile_TD_error_flag,
    input  logic [NUM_TILES-1:0]       tile_recovery_done,
    input  logic [NUM_TILES-1:0]       tile_recovery_success,
    output logic [NUM_TILES-1:0]       tile_START,
    output logic [NUM_TILES-1:0]       tile_test_mode,
    output logic [NUM_TILES-1:0]       tile_BIST_mode,
    output logic                       busy,
    output logic                       sched_done,
    output logic [TILE_ID_WIDTH-1:0]   cur_tile,
    output logic [NUM_TILES-1:0]       tile_pass,
    output logic [4*NUM_TILES-1:0]     tile_fail_code
);

    localparam int NT = NUM_TILES;
    localparam int TW = TIMEOUT_WIDTH;
    localparam int IW = TILE_ID_WIDTH;

    sched_state_e      r_state, w_state_nxt;
    logic [2:0]        r_mask;
    logic [NT-1:0]     r_en;
    logic [TW-1:0]     r_limit, r_wd, w_wd_nxt;
    logic [IW-1:0]     r_cur, w_cur_nxt;
    logic [3:0]        r_code, w_code_nxt;
    logic [NT-1:0]     r_pass;
    logic [4*NT-1:0]   r_fcode;
    logic              w_found, w_accept, w_log;
    logic              w_tmo, w_tmo_hit;
    logic [IW-1:0]     w_idx;
    logic [NT-1:0]     w_onehot;
    sched_state_e      w_first, w_after_mb, w_after_lb;
`ifdef STRAIT_SCHED_RETRY_EN
    logic              r_retry, w_retry_nxt;
`endif

    strait_sched_tile_pick #(
        .NUM_TILES    (NT),
        .TILE_ID_WIDTH(IW)
    ) u_pick (
        .i_enable(r_en),
        .i_start (r_cur),
        .o_found (w_found),
        .o_index (w_idx)
    );

    assign w_after_lb = r_mask[PM_REC] ? S_REC_WAIT : S_LOG;
    assign w_after_mb = r_mask[PM_LBIST] ? S_LB_START : w_after_lb;
    assign w_first    = r_mask[PM_MBIST] ? S_MB_START : w_after_mb;
    assign w_tmo      = (r_limit != '0) && (r_wd == r_limit);
    assign w_onehot   = NT'(1) << r_cur;

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_code_nxt  = r_code;
        w_wd_nxt    = r_wd + TW'(1);
        w_accept    = 1'b0;
        w_log       = 1'b0;
        w_tmo_hit   = 1'b0;
`ifdef STRAIT_SCHED_RETRY_EN
        w_retry_nxt = r_retry;
`endif
        case (r_state)
            S_IDLE: begin
                if (sched_start) begin
                    w_accept    = 1'b1;
                    w_cur_nxt   = '0;
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                w_code_nxt = '0;
                if (r_mask == 3'b000 || !w_found) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cur_nxt   = w_idx;
                    w_state_nxt = w_first;
                end
            end
            S_MB_START: w_state_nxt = S_MB_WAIT;
            S_MB_WAIT: begin
                if (tile_test_done[r_cur]) begin
                    w_code_nxt[FC_MBIST] = tile_MBIST_FAIL[r_cur];
                    w_state_nxt          = w_after_mb;
                end else if (w_tmo) begin
                    w_tmo_hit = 1'b1;
                end
            end
            S_LB_START: w_state_nxt = S_LB_WAIT_SA;
            S_LB_WAIT_SA: begin
                if (tile_test_done[r_cur]) begin
                    w_state_nxt = S_LB_WAIT_TD;
                end else if (w_tmo) begin
                    w_tmo_hit = 1'b1;
                end
            end
            S_LB_WAIT_TD: begin
                if (tile_test_done[r_cur]) begin
                    w_code_nxt[FC_TD] = tile_TD_error_flag[r_cur];
                    w_state_nxt       = w_after_lb;
                end else if (w_tmo) begin
                    w_tmo_hit = 1'b1;
                end
            end
            S_REC_WAIT: begin
                if (tile_recovery_done[r_cur]) begin
                    w_code_nxt[FC_UNREC] = ~tile_recovery_success[r_cur];
                    w_state_nxt          = S_LOG;
                end else if (w_tmo) begin
                    w_tmo_hit = 1'b1;
                end
            end
            S_LOG: begin
                w_log = 1'b1;
                if (r_cur == IW'(NT - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cur_nxt   = r_cur + IW'(1);
                    w_state_nxt = S_SELECT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt != r_state) w_wd_nxt = '0;

        if (w_tmo_hit) begin
`ifdef STRAIT_SCHED_RETRY_EN
            if (!r_retry) begin
                w_retry_nxt = 1'b1;
                w_wd_nxt    = '0;
                case (r_state)
                    S_MB_WAIT:  w_state_nxt = S_MB_START;
                    S_REC_WAIT: w_state_nxt = S_REC_WAIT;
                    default:    w_state_nxt = S_LB_START;
                endcase
            end else begin
                w_code_nxt[FC_TIMEOUT] = 1'b1;
                w_state_nxt            = S_LOG;
            end
`else
            w_code_nxt[FC_TIMEOUT] = 1'b1;
            w_state_nxt            = S_LOG;
`endif
        end

`ifdef STRAIT_SCHED_RETRY_EN
        // A phase that ends normally hands a fresh allowance to the next one
        if (!w_tmo_hit && (w_state_nxt != r_state) &&
            (r_state inside {S_SELECT, S_MB_WAIT, S_LB_WAIT_TD, S_REC_WAIT}))
            w_retry_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_en    <= '0;
            r_limit <= '0;
            r_wd    <= '0;
            r_cur   <= '0;
            r_code  <= '0;
            r_pass  <= '0;
            r_fcode <= '0;
`ifdef STRAIT_SCHED_RETRY_EN
            r_retry <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_wd    <= w_wd_nxt;
            r_cur   <= w_cur_nxt;
            r_code  <= w_code_nxt;
`ifdef STRAIT_SCHED_RETRY_EN
            r_retry <= w_retry_nxt;
`endif
            if (w_accept) begin
                r_mask  <= phase_mask;
                r_en    <= tile_enable;
                r_limit <= timeout_limit;
                r_pass  <= '0;
                r_fcode <= '0;
            end
            if (w_log) begin
                r_fcode[4*r_cur +: 4] <= r_code;
                r_pass[r_cur]         <= (r_code == 4'b0000);
            end
        end
    end

    assign tile_START = (r_state inside {S_MB_START, S_LB_START}) ?
                        w_onehot : '0;
    assign tile_test_mode = (r_state inside {S_MB_START, S_MB_WAIT,
                            S_LB_START, S_LB_WAIT_SA, S_LB_WAIT_TD,
                            S_REC_WAIT}) ? w_onehot : '0;
    assign tile_BIST_mode = (r_state inside {S_LB_START, S_LB_WAIT_SA,
                            S_LB_WAIT_TD}) ? w_onehot : '0;
    assign busy           = (r_state != S_IDLE);
    assign sched_done     = (r_state == S_DONE);
    assign cur_tile       = r_cur;
    assign tile_pass      = r_pass;
    assign tile_fail_code = r_fcode;

endmodule

// File: tb/tb_strait_test_scheduler.sv
// Directed bench for strait_test_scheduler with a small per-tile responder.
// Timeout expectations follow STRAIT_SCHED_RETRY_EN when it is defined.
module tb_strait_test_scheduler;

    localparam int NT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            sched_start;
    logic [2:0]      phase_mask;
    logic [NT-1:0]   tile_enable;
    logic [15:0]     timeout_limit;
    logic [NT-1:0]   tile_test_done;
    logic [NT-1:0]   mb_fail, td_err, rec_done, rec_ok;
    logic [NT-1:0]   tile_START, tile_test_mode, tile_BIST_mode;
    logic            busy, sched_done;
    logic [1:0]      cur_tile;
    logic [NT-1:0]   tile_pass;
    logic [4*NT-1:0] tile_fail_code;

    logic [NT-1:0]   resp_done, inj_done, hang_td;
    logic [NT-1:0]   mon_oh;
    int cyc = 0;
    int done_cnt, done_cyc, viol, n_cmp, n_bad, acc;
    int st_code[$];
    int st_cyc[$];
    int cnt[NT];
    int stage[NT];

    assign tile_test_done = resp_done | inj_done;

    strait_test_scheduler #(
        .NUM_TILES(NT), .TIMEOUT_WIDTH(16), .TILE_ID_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .sched_start(sched_start),
        .phase_mask(phase_mask), .tile_enable(tile_enable),
        .timeout_limit(timeout_limit), .tile_test_done(tile_test_done),
        .tile_MBIST_FAIL(mb_fail), .tile_TD_error_flag(td_err),
        .tile_recovery_done(rec_done), .tile_recovery_success(rec_ok),
        .tile_START(tile_START), .tile_test_mode(tile_test_mode),
        .tile_BIST_mode(tile_BIST_mode), .busy(busy),
        .sched_done(sched_done), .cur_tile(cur_tile),
        .tile_pass(tile_pass), .tile_fail_code(tile_fail_code)
    );

    initial forever #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tile model: done 3 cycles after START; LBIST gives SA then TD
    initial begin
        resp_done = '0;
        for (int t = 0; t < NT; t++) begin
            cnt[t] = 0;
            stage[t] = 0;
        end
        done_cnt = 0;
        viol = 0;
        forever begin
            @(negedge clk);
            resp_done = '0;
            for (int t = 0; t < NT; t++) begin
                if (tile_START[t]) begin
                    stage[t] = tile_BIST_mode[t] ? 2 : 1;
                    cnt[t] = 3;
                end else if (stage[t] != 0) begin
                    cnt[t]--;
                    if (cnt[t] == 0) begin
                        if (stage[t] == 3 && hang_td[t]) begin
                            stage[t] = 0;
                        end else begin
                            resp_done[t] = 1'b1;
                            if (stage[t] == 2) begin
                                stage[t] = 3;
                                cnt[t] = 3;
                            end else begin
                                stage[t] = 0;
                            end
                        end
                    end
                end
            end
            if (sched_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (|tile_START) begin
                st_code.push_back(int'(cur_tile) * 2 + int'(tile_BIST_mode[cur_tile]));
                st_cyc.push_back(cyc);
            end
            mon_oh = NT'(1) << cur_tile;
            if (((tile_START | tile_test_mode | tile_BIST_mode) & ~mon_oh) != '0)
                viol++;
            if (!busy && ((tile_START | tile_test_mode | tile_BIST_mode) != '0))
                viol++;
        end
    end

    task automatic run_sched(input logic [NT-1:0] en, input logic [2:0] pm,
                             input logic [15:0] lim);
        @(negedge clk);
        tile_enable = en;
        phase_mask = pm;
        timeout_limit = lim;
        st_code.delete();
        st_cyc.delete();
        done_cnt = 0;
        sched_start = 1'b1;
        acc = cyc;
        @(negedge clk);
        sched_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, (done_cnt != 0), 1);
        repeat (3) @(negedge clk);
        chk({tag, "_once"}, done_cnt, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_first_start();
        int k;
        k = 0;
        while (st_code.size() == 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("first_start_seen", (st_code.size() != 0), 1);
    endtask

    task automatic chk_seq(input string tag, input int exp[8], input int n);
        chk({tag, "_nstart"}, st_code.size(), n);
        for (int i = 0; i < n && i < st_code.size(); i++)
            chk(tag, st_code[i], exp[i]);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        sched_start = 1'b0;
        phase_mask = '0;
        tile_enable = '0;
        timeout_limit = '0;
        inj_done = '0;
        hang_td = '0;
        mb_fail = '0;
        td_err = '0;
        rec_done = '1;
        rec_ok = '1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", sched_done, 0);
        chk("rst_cur", cur_tile, 0);
        chk("rst_pass", tile_pass, 0);
        chk("rst_code", tile_fail_code, 0);
        chk("rst_mode", {tile_START, tile_test_mode, tile_BIST_mode}, 0);
        rst = 1'b0;

        // Clean run with tile 2 disabled
        run_sched(4'b1011, 3'b111, 16'd0);
        chk("t1_busy", busy, 1);
        wait_done("t1_done");
        chk_seq("t1_seq", '{0, 1, 2, 3, 6, 7, 0, 0}, 6);
        chk("t1_lat", st_cyc[0] - acc, 2);
        chk("t1_pass", tile_pass, 4'b1011);
        chk("t1_code", tile_fail_code, 16'h0000);

        // MBIST failure on tile 1, remaining phases still run
        mb_fail = 4'b0010;
        run_sched(4'b0011, 3'b111, 16'd100);
        wait_done("t2_done");
        chk_seq("t2_seq", '{0, 1, 2, 3, 0, 0, 0, 0}, 4);
        chk("t2_pass", tile_pass, 4'b0001);
        chk("t2_code", tile_fail_code, 16'h0010);
        mb_fail = '0;

        // Tile 0 never finishes TD: watchdog at 20
        hang_td = 4'b0001;
        run_sched(4'b0011, 3'b010, 16'd20);
        wait_done("t3_done");
`ifdef STRAIT_SCHED_RETRY_EN
        chk_seq("t3_seq", '{1, 1, 3, 0, 0, 0, 0, 0}, 3);
        chk("t3_gap", st_cyc[st_cyc.size() - 1] - st_cyc[0], 52);
`else
        chk_seq("t3_seq", '{1, 3, 0, 0, 0, 0, 0, 0}, 2);
        chk("t3_gap", st_cyc[st_cyc.size() - 1] - st_cyc[0], 27);
`endif
        chk("t3_pass", tile_pass, 4'b0010);
        chk("t3_code", tile_fail_code, 16'h0008);
        hang_td = '0;

        // Recovery only, tile 0 unrecovered
        rec_ok = 4'b0100;
        run_sched(4'b0101, 3'b100, 16'd0);
        wait_done("t4_done");
        chk("t4_nstart", st_code.size(), 0);
        chk("t4_pass", tile_pass, 4'b0100);
        chk("t4_code", tile_fail_code, 16'h0004);
        rec_ok = '1;

        // Nothing enabled: done two cycles after accept
        run_sched(4'b0000, 3'b111, 16'd0);
        wait_done("t5_done");
        chk("t5_lat", done_cyc - acc, 2);
        chk("t5_pass", tile_pass, 4'b0000);

        // Restart request and stray done pulses mid-run are ignored
        run_sched(4'b0011, 3'b111, 16'd0);
        wait_first_start();
        @(negedge clk);
        inj_done = 4'b1110;
        sched_start = 1'b1;
        @(negedge clk);
        inj_done = '0;
        sched_start = 1'b0;
        wait_done("t6_done");
        chk_seq("t6_seq", '{0, 1, 2, 3, 0, 0, 0, 0}, 4);
        chk("t6_pass", tile_pass, 4'b0011);
        chk("t6_code", tile_fail_code, 16'h0000);

        // Reset while tile 0 sits in MB_WAIT
        run_sched(4'b0001, 3'b001, 16'd0);
        wait_first_start();
        @(negedge clk);
        chk("t7_inwait", {busy, tile_test_mode, tile_START}, 9'b1_0001_0000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t7_busy", busy, 0);
        chk("t7_outs", {tile_START, tile_test_mode, tile_BIST_mode, sched_done}, 0);
        chk("t7_cur", cur_tile, 0);
        chk("t7_res", {tile_pass, tile_fail_code}, 0);
        repeat (4) @(negedge clk);
        run_sched(4'b0001, 3'b001, 16'd0);
        wait_done("t7_done");
        chk_seq("t7_seq", '{0, 0, 0, 0, 0, 0, 0, 0}, 1);
        chk("t7_pass", tile_pass, 4'b0001);

        chk("onehot_viol", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
